// File: rtl/cache_controller.sv
// cache_controller: sequencing FSM beside the cache datapath.
//
// Accepts load/store requests, drives the datapath control strobes (lookup, hit write,
// victim writeback, line fill, metadata updates) and runs the word-by-word higher-memory
// handshake during miss recovery. Also keeps saturating hit/miss/writeback counters.
//
// Parameters:
//   READ_ONLY  : 1 = no stores, no dirty tracking, no writeback path (I-cache)
//   STAT_WIDTH : width of each statistics counter
// Ports:
//   clk, reset_n              : clock, synchronous active-low reset
//   req_valid/req_is_store    : upstream request (held until req_fulfilled)
//   req_fulfilled             : one-cycle completion pulse
//   hmem_req_*                : higher-memory word handshake
//   valid_block_match, valid_dirty_bit, counter_done : datapath status
//   miss_recovery_mode .. decrement_counter          : datapath strobes
//   hit_count, miss_count, writeback_count           : saturating statistics
module cache_controller #(
  parameter bit          READ_ONLY  = 1'b0,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic                  req_is_store,
  output logic                  req_fulfilled,
  output logic                  hmem_req_valid,
  output logic                  hmem_req_is_store,
  input  logic                  hmem_req_fulfilled,
  input  logic                  valid_block_match,
  input  logic                  valid_dirty_bit,
  input  logic                  counter_done,
  output logic                  miss_recovery_mode,
  output logic                  process_lru_counters,
  output logic                  perform_write,
  output logic                  set_selected_dirty_bit,
  output logic                  clear_selected_dirty_bit,
  output logic                  clear_selected_valid_bit,
  output logic                  finish_new_line_install,
  output logic                  set_hmem_block_address,
  output logic                  use_victim_tag_for_hmem_block_address,
  output logic                  reset_counter,
  output logic                  decrement_counter,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count,
  output logic [STAT_WIDTH-1:0] writeback_count
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StCompare   = 2'd1;
  localparam logic [1:0] StWriteback = 2'd2;
  localparam logic [1:0] StFill      = 2'd3;

  logic [1:0] state_q, state_d;
  logic [STAT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic [STAT_WIDTH-1:0] miss_count_q, miss_count_d;
  logic [STAT_WIDTH-1:0] writeback_count_q, writeback_count_d;
  logic hit_inc, miss_inc, wb_inc;

  always_comb begin
    state_d                               = state_q;
    hit_inc                               = 1'b0;
    miss_inc                              = 1'b0;
    wb_inc                                = 1'b0;
    req_fulfilled                         = 1'b0;
    hmem_req_valid                        = 1'b0;
    hmem_req_is_store                     = 1'b0;
    miss_recovery_mode                    = 1'b0;
    process_lru_counters                  = 1'b0;
    perform_write                         = 1'b0;
    set_selected_dirty_bit                = 1'b0;
    clear_selected_dirty_bit              = 1'b0;
    clear_selected_valid_bit              = 1'b0;
    finish_new_line_install               = 1'b0;
    set_hmem_block_address                = 1'b0;
    use_victim_tag_for_hmem_block_address = 1'b0;
    reset_counter                         = 1'b0;
    decrement_counter                     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) state_d = StCompare;
      end

      StCompare: begin
        if (!req_valid) begin
          // Request withdrawn: drop back silently.
          state_d = StIdle;
        end else if (READ_ONLY && req_is_store) begin
          // Stores are acknowledged but otherwise ignored in a read-only cache.
          req_fulfilled = 1'b1;
          state_d       = StIdle;
        end else if (valid_block_match) begin
          req_fulfilled        = 1'b1;
          process_lru_counters = 1'b1;
          hit_inc              = 1'b1;
          if (req_is_store) begin
            perform_write          = 1'b1;
            set_selected_dirty_bit = 1'b1;
          end
          state_d = StIdle;
        end else begin
          miss_inc               = 1'b1;
          miss_recovery_mode     = 1'b1;
          set_hmem_block_address = 1'b1;
          reset_counter          = 1'b1;
          if (!READ_ONLY && valid_dirty_bit) begin
            use_victim_tag_for_hmem_block_address = 1'b1;
            state_d                               = StWriteback;
          end else begin
            // Invalidate up front so an abandoned fill never leaves a stale valid line.
            clear_selected_valid_bit = 1'b1;
            state_d                  = StFill;
          end
        end
      end

      StWriteback: begin
        miss_recovery_mode = 1'b1;
        hmem_req_valid     = 1'b1;
        hmem_req_is_store  = 1'b1;
        if (hmem_req_fulfilled) begin
          if (counter_done) begin
            clear_selected_dirty_bit = 1'b1;
            clear_selected_valid_bit = 1'b1;
            // Re-latch the block address with the request tag for the fill.
            set_hmem_block_address   = 1'b1;
            reset_counter            = 1'b1;
            wb_inc                   = 1'b1;
            state_d                  = StFill;
          end else begin
            decrement_counter = 1'b1;
          end
        end
      end

      StFill: begin
        miss_recovery_mode = 1'b1;
        hmem_req_valid     = 1'b1;
        if (hmem_req_fulfilled) begin
          perform_write = 1'b1;
          if (counter_done) begin
            finish_new_line_install = 1'b1;
            // Replay the lookup; it hits and completes the request.
            state_d                 = StCompare;
          end else begin
            decrement_counter = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    hit_count_d       = hit_count_q;
    miss_count_d      = miss_count_q;
    writeback_count_d = writeback_count_q;
    if (hit_inc && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + STAT_WIDTH'(1);
    end
    if (miss_inc && (miss_count_q != '1)) begin
      miss_count_d = miss_count_q + STAT_WIDTH'(1);
    end
    if (wb_inc && (writeback_count_q != '1)) begin
      writeback_count_d = writeback_count_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= StIdle;
      hit_count_q       <= '0;
      miss_count_q      <= '0;
      writeback_count_q <= '0;
    end else begin
      state_q           <= state_d;
      hit_count_q       <= hit_count_d;
      miss_count_q      <= miss_count_d;
      writeback_count_q <= writeback_count_d;
    end
  end

  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;
  assign writeback_count = writeback_count_q;

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller: instance A (READ_ONLY=0, 32-bit stats) runs against a small
// one-set datapath model and a configurable-latency memory responder; instance B
// (READ_ONLY=1, 4-bit stats) is driven directly. Expected responses are queued at issue
// time and checked by monitor processes when req_fulfilled appears.
module tb_cache_controller;

  logic clk;
  logic reset_n;

  // Instance A signals
  logic req_valid, req_is_store, req_fulfilled;
  logic hmem_req_valid, hmem_req_is_store, hmem_req_fulfilled;
  logic valid_block_match, valid_dirty_bit, counter_done;
  logic miss_recovery_mode, process_lru_counters, perform_write, set_selected_dirty_bit;
  logic clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install;
  logic set_hmem_block_address, use_victim_tag_for_hmem_block_address;
  logic reset_counter, decrement_counter;
  logic [31:0] hit_count, miss_count, writeback_count;

  // Instance B signals
  logic b_req_valid, b_req_is_store, b_req_fulfilled;
  logic b_hmem_req_valid, b_hmem_req_is_store, b_hmem_req_fulfilled;
  logic b_match, b_dirty, b_done;
  logic b_mrm, b_lru, b_pw, b_sdb, b_cdb, b_cvb, b_fin, b_sha, b_uvt, b_rc, b_dc;
  logic [3:0] b_hit_count, b_miss_count, b_writeback_count;

  cache_controller #(.READ_ONLY(1'b0), .STAT_WIDTH(32)) u_dut_a (
    .clk                                   (clk),
    .reset_n                               (reset_n),
    .req_valid                             (req_valid),
    .req_is_store                          (req_is_store),
    .req_fulfilled                         (req_fulfilled),
    .hmem_req_valid                        (hmem_req_valid),
    .hmem_req_is_store                     (hmem_req_is_store),
    .hmem_req_fulfilled                    (hmem_req_fulfilled),
    .valid_block_match                     (valid_block_match),
    .valid_dirty_bit                       (valid_dirty_bit),
    .counter_done                          (counter_done),
    .miss_recovery_mode                    (miss_recovery_mode),
    .process_lru_counters                  (process_lru_counters),
    .perform_write                         (perform_write),
    .set_selected_dirty_bit                (set_selected_dirty_bit),
    .clear_selected_dirty_bit              (clear_selected_dirty_bit),
    .clear_selected_valid_bit              (clear_selected_valid_bit),
    .finish_new_line_install               (finish_new_line_install),
    .set_hmem_block_address                (set_hmem_block_address),
    .use_victim_tag_for_hmem_block_address (use_victim_tag_for_hmem_block_address),
    .reset_counter                         (reset_counter),
    .decrement_counter                     (decrement_counter),
    .hit_count                             (hit_count),
    .miss_count                            (miss_count),
    .writeback_count                       (writeback_count)
  );

  cache_controller #(.READ_ONLY(1'b1), .STAT_WIDTH(4)) u_dut_b (
    .clk                                   (clk),
    .reset_n                               (reset_n),
    .req_valid                             (b_req_valid),
    .req_is_store                          (b_req_is_store),
    .req_fulfilled                         (b_req_fulfilled),
    .hmem_req_valid                        (b_hmem_req_valid),
    .hmem_req_is_store                     (b_hmem_req_is_store),
    .hmem_req_fulfilled                    (b_hmem_req_fulfilled),
    .valid_block_match                     (b_match),
    .valid_dirty_bit                       (b_dirty),
    .counter_done                          (b_done),
    .miss_recovery_mode                    (b_mrm),
    .process_lru_counters                  (b_lru),
    .perform_write                         (b_pw),
    .set_selected_dirty_bit                (b_sdb),
    .clear_selected_dirty_bit              (b_cdb),
    .clear_selected_valid_bit              (b_cvb),
    .finish_new_line_install               (b_fin),
    .set_hmem_block_address                (b_sha),
    .use_victim_tag_for_hmem_block_address (b_uvt),
    .reset_counter                         (b_rc),
    .decrement_counter                     (b_dc),
    .hit_count                             (b_hit_count),
    .miss_count                            (b_miss_count),
    .writeback_count                       (b_writeback_count)
  );

  logic [13:0] a_outs, b_outs;
  assign a_outs = {req_fulfilled, hmem_req_valid, hmem_req_is_store, miss_recovery_mode,
                   process_lru_counters, perform_write, set_selected_dirty_bit,
                   clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install,
                   set_hmem_block_address, use_victim_tag_for_hmem_block_address,
                   reset_counter, decrement_counter};
  assign b_outs = {b_req_fulfilled, b_hmem_req_valid, b_hmem_req_is_store, b_mrm, b_lru, b_pw,
                   b_sdb, b_cdb, b_cvb, b_fin, b_sha, b_uvt, b_rc, b_dc};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One-set datapath model for instance A: 8 words per line, counter counts 7 down to 0.
  logic [7:0] cur_tag = 8'd0;
  logic [7:0] line_tag = 8'd0;
  logic [7:0] hmem_tag = 8'd0;
  logic       line_valid = 1'b0;
  logic       line_dirty = 1'b0;
  logic [2:0] cnt = 3'd0;

  assign valid_block_match = line_valid && (line_tag == cur_tag);
  assign valid_dirty_bit   = line_valid && line_dirty;
  assign counter_done      = (cnt == 3'd0);

  always @(posedge clk) begin
    if (reset_counter) cnt <= 3'd7;
    else if (decrement_counter) cnt <= cnt - 3'd1;
    if (set_hmem_block_address) begin
      hmem_tag <= use_victim_tag_for_hmem_block_address ? line_tag : cur_tag;
    end
    if (set_selected_dirty_bit) line_dirty <= 1'b1;
    if (clear_selected_dirty_bit) line_dirty <= 1'b0;
    if (clear_selected_valid_bit) line_valid <= 1'b0;
    if (finish_new_line_install) begin
      line_valid <= 1'b1;
      line_dirty <= 1'b0;
      line_tag   <= cur_tag;
    end
  end

  // Higher-memory responder: answers after 'stall' idle cycles per word.
  int stall = 0;
  int wait_cnt = 0;
  initial begin
    hmem_req_fulfilled = 1'b0;
    forever begin
      @(negedge clk);
      if (hmem_req_valid && reset_n) begin
        if (wait_cnt >= stall) begin
          hmem_req_fulfilled = 1'b1;
          wait_cnt = 0;
        end else begin
          hmem_req_fulfilled = 1'b0;
          wait_cnt++;
        end
      end else begin
        hmem_req_fulfilled = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  typedef struct {
    int issue_cyc;
    int lat;
    int fills;
    int wbs;
    int installs;
    int writes;
    int hit;
    int miss;
    int wbc;
  } exp_t;

  exp_t sb_q[$];

  // Monitor A: per-transaction event counters, checked when req_fulfilled appears.
  int fills = 0, fill_ok = 0, wbs = 0, wb_victim = 0, installs = 0, writes = 0;
  bit seen_fill = 0, order_bad = 0, stat_pending = 0;
  exp_t pend;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        fills = 0; fill_ok = 0; wbs = 0; wb_victim = 0; installs = 0; writes = 0;
        seen_fill = 0; order_bad = 0; stat_pending = 0;
      end else begin
        if (stat_pending) begin
          chk("hit_count", hit_count, pend.hit);
          chk("miss_count", miss_count, pend.miss);
          chk("writeback_count", writeback_count, pend.wbc);
          stat_pending = 0;
        end
        if (hmem_req_valid && hmem_req_fulfilled) begin
          if (hmem_req_is_store) begin
            wbs++;
            if (hmem_tag == line_tag) wb_victim++;
            if (seen_fill) order_bad = 1;
          end else begin
            fills++;
            if (hmem_tag == cur_tag) fill_ok++;
            seen_fill = 1;
          end
        end
        if (finish_new_line_install) installs++;
        if (perform_write) writes++;
        if (req_fulfilled) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_fulfil", 1, 0);
          end else begin
            pend = sb_q.pop_front();
            chk("latency", cyc - pend.issue_cyc, pend.lat);
            chk("fill_words", fills, pend.fills);
            chk("fill_addr_req_tag", fill_ok, pend.fills);
            chk("wb_words", wbs, pend.wbs);
            chk("wb_addr_victim_tag", wb_victim, pend.wbs);
            chk("wb_before_fill", order_bad, 0);
            chk("installs", installs, pend.installs);
            chk("perform_writes", writes, pend.writes);
            stat_pending = 1;
          end
          fills = 0; fill_ok = 0; wbs = 0; wb_victim = 0; installs = 0; writes = 0;
          seen_fill = 0; order_bad = 0;
        end
      end
    end
  end

  task automatic issue(input logic st, input int tag, input int lat, input int nf, input int nw,
                       input int ni, input int nwr, input int eh, input int em, input int ew);
    exp_t e;
    int n;
    @(negedge clk);
    #2;
    cur_tag = 8'(tag);
    req_is_store = st;
    req_valid = 1'b1;
    e.issue_cyc = cyc; e.lat = lat; e.fills = nf; e.wbs = nw; e.installs = ni;
    e.writes = nwr; e.hit = eh; e.miss = em; e.wbc = ew;
    sb_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!req_fulfilled && n < 200);
    if (!req_fulfilled) begin
      bad++; total++;
      $display("FAIL req_timeout: got no req_fulfilled expected one within 200 cycles");
      if (sb_q.size() > 0) void'(sb_q.pop_back());
      req_valid = 1'b0;
    end else begin
      // Hold the request across the fulfilling edge, then withdraw it.
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  // Monitor B: read-only instance must never write or touch higher memory.
  int b_q[$];
  bit b_pw_seen = 0, b_hv_seen = 0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        if (b_pw) b_pw_seen = 1;
        if (b_hmem_req_valid) b_hv_seen = 1;
        if (b_req_fulfilled) begin
          if (b_q.size() == 0) begin
            chk("b_unexpected_fulfil", 1, 0);
          end else begin
            chk("b_latency", cyc - b_q.pop_front(), 1);
            chk("b_perform_write_seen", b_pw_seen, 0);
            chk("b_hmem_valid_seen", b_hv_seen, 0);
          end
          b_pw_seen = 0;
          b_hv_seen = 0;
        end
      end
    end
  end

  task automatic b_issue(input logic st);
    int n;
    @(negedge clk);
    #2;
    b_req_is_store = st;
    b_req_valid = 1'b1;
    b_q.push_back(cyc);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!b_req_fulfilled && n < 20);
    if (!b_req_fulfilled) begin
      bad++; total++;
      $display("FAIL b_req_timeout: got no req_fulfilled expected one within 20 cycles");
      if (b_q.size() > 0) void'(b_q.pop_back());
    end else begin
      @(posedge clk);
      #1;
    end
    b_req_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_outs_a"}, a_outs, 0);
    chk({nm, "_hit"}, hit_count, 0);
    chk({nm, "_miss"}, miss_count, 0);
    chk({nm, "_wb"}, writeback_count, 0);
    chk({nm, "_outs_b"}, b_outs, 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0;
    b_req_valid = 1'b0; b_req_is_store = 1'b0;
    b_match = 1'b0; b_dirty = 1'b1; b_done = 1'b1; b_hmem_req_fulfilled = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state("reset");
    #1;
    reset_n = 1'b1;

    // Cold load: COMPARE + 8 fills + replay.
    issue(1'b0, 1, 10, 8, 0, 1, 8, 1, 1, 0);
    // Same line again: single-cycle hit.
    issue(1'b0, 1, 1, 0, 0, 0, 0, 2, 1, 0);
    // Store hit dirties the line.
    issue(1'b1, 1, 1, 0, 0, 0, 1, 3, 1, 0);
    // Conflicting load: 8 writeback words then 8 fill words.
    issue(1'b0, 2, 18, 8, 8, 1, 8, 4, 2, 1);
    // Clean miss with 3 stall cycles per word.
    stall = 3;
    issue(1'b0, 3, 34, 8, 0, 1, 8, 5, 3, 1);

    // Slow fill interrupted by reset after word 4.
    @(negedge clk);
    #2;
    cur_tag = 8'd4;
    req_is_store = 1'b0;
    req_valid = 1'b1;
    n = 0;
    while (fills < 4 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (fills < 4) begin
      bad++; total++;
      $display("FAIL abort_fill_timeout: got %0d fill words expected 4", fills);
    end
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_state("midfill_reset");
    #1;
    req_valid = 1'b0;
    reset_n = 1'b1;
    stall = 0;

    // Line was invalidated before the abort, so the same load misses again.
    issue(1'b0, 4, 10, 8, 0, 1, 8, 1, 1, 0);
    issue(1'b1, 4, 1, 0, 0, 0, 1, 2, 1, 0);
    issue(1'b0, 5, 18, 8, 8, 1, 8, 3, 2, 1);

    // Read-only instance: store on a dirty-looking miss is acknowledged only.
    b_match = 1'b0;
    b_issue(1'b1);
    @(negedge clk);
    #1;
    chk("b_store_hit", b_hit_count, 0);
    chk("b_store_miss", b_miss_count, 0);
    chk("b_store_wb", b_writeback_count, 0);
    // 20 load hits saturate the 4-bit hit counter at 15.
    b_match = 1'b1;
    for (int i = 0; i < 20; i++) b_issue(1'b0);
    @(negedge clk);
    #1;
    chk("b_hit_saturated", b_hit_count, 15);
    chk("b_miss_after_hits", b_miss_count, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("b_queue_drained", b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
